// File: rtl/agg_reduce_if.sv
// ---------------------------------------------------------------------------
// agg_reduce_if
//   AXI4-Stream style bundle used on both sides of agg_reduce.
//   Ports (signals):
//     tdata  [DW-1:0]   beat payload
//     tkeep  [DW/8-1:0] byte enables
//     tuser  [UW-1:0]   sideband
//     tvalid            source has a beat
//     tready            sink can take a beat
//     tlast             last beat of packet
//   master modport: drives everything except tready.
//   slave modport:  drives tready only.
// ---------------------------------------------------------------------------
interface agg_reduce_if #(
  parameter int DW = 256,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (
    output tdata, tkeep, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/agg_reduce.sv
// ---------------------------------------------------------------------------
// agg_reduce
//   Reduces NUM_WORKERS aggregation packets of one round into one result
//   packet. Every packet is PKT_BEATS beats: beat 0 is a header, the rest carry
//   8 x 32-bit integer lanes. Non-final packets are summed lane-wise into an
//   accumulator; the final packet is emitted as its header followed by
//   (accumulator + payload), through a single registered output stage.
//
//   Ports:
//     axis_aclk       clock
//     axis_reset      asynchronous, active-high reset
//     s_axis_agg      input stream (slave modport); tkeep is ignored
//     m_axis          result stream (master modport); tkeep is all ones
//     round_done      1-cycle pulse after a result tlast beat is accepted
//     pkt_cnt         well-formed packets absorbed or emitted (wraps)
//     err_cnt         malformed packets (saturates at 16'hFFFF)
//     state_dbg       current FSM state (HDR=0, ABSORB=1, EMIT=2, DRAIN=3)
//     worker_cnt_dbg  packets absorbed so far in the current round
//     beat_idx_dbg    beat position inside the current packet
// ---------------------------------------------------------------------------
module agg_reduce #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int PKT_BEATS          = 3,
  parameter int NUM_WORKERS        = 4
) (
  input  logic         axis_aclk,
  input  logic         axis_reset,
  agg_reduce_if.slave  s_axis_agg,
  agg_reduce_if.master m_axis,
  output logic         round_done,
  output logic [31:0]  pkt_cnt,
  output logic [15:0]  err_cnt,
  output logic [1:0]   state_dbg,
  output logic [7:0]   worker_cnt_dbg,
  output logic [3:0]   beat_idx_dbg
);

  localparam int DW    = C_AXIS_DATA_WIDTH;
  localparam int UW    = C_AXIS_TUSER_WIDTH;
  localparam int LANES = DW / 32;
  localparam int NACC  = PKT_BEATS - 1;

  localparam logic [3:0] LAST_BEAT    = 4'(PKT_BEATS - 1);
  localparam logic [7:0] FINAL_WORKER = 8'(NUM_WORKERS - 1);

  typedef enum logic [1:0] {
    HDR    = 2'd0,
    ABSORB = 2'd1,
    EMIT   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t         state;
  logic [3:0]     beat_idx;
  logic [7:0]     worker_cnt;
  logic [UW-1:0]  hdr_tuser;
  logic [DW-1:0]  acc [NACC];
  logic [DW-1:0]  cur_acc;
  logic [DW-1:0]  beat_sum;
  logic           in_fire;
  logic           is_final;
  logic           unused_tkeep;

  // Lane-wise modulo-2^32 add; no carry crosses a lane boundary.
  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      r[l*32 +: 32] = a[l*32 +: 32] + b[l*32 +: 32];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Handshake: a beat moves on any edge where tvalid & tready are both high.
  // A source keeps tvalid and its payload stable until that edge. The input
  // is ready whenever the output register is empty or being drained this
  // cycle; ABSORB and DRAIN never write the output, so they are always ready.
  assign s_axis_agg.tready = (state == ABSORB || state == DRAIN) ? 1'b1
                           : (~m_axis.tvalid | m_axis.tready);
  assign in_fire  = s_axis_agg.tvalid & s_axis_agg.tready;
  assign is_final = (worker_cnt == FINAL_WORKER);

  assign m_axis.tkeep = '1;
  assign unused_tkeep = ^s_axis_agg.tkeep;

  assign state_dbg      = state;
  assign worker_cnt_dbg = worker_cnt;
  assign beat_idx_dbg   = beat_idx;

  // Accumulator slot k holds the running sum for data beat k+1.
  always_comb begin
    cur_acc = '0;
    for (int k = 0; k < NACC; k++) begin
      if (beat_idx == 4'(k + 1)) cur_acc = acc[k];
    end
  end

  assign beat_sum = lane_add(cur_acc, s_axis_agg.tdata);

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state         <= HDR;
      beat_idx      <= '0;
      worker_cnt    <= '0;
      hdr_tuser     <= '0;
      for (int k = 0; k < NACC; k++) acc[k] <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tuser  <= '0;
      m_axis.tlast  <= 1'b0;
      round_done    <= 1'b0;
      pkt_cnt       <= '0;
      err_cnt       <= '0;
    end else begin
      round_done <= m_axis.tvalid & m_axis.tready & m_axis.tlast;
      // Output drains by default; a load below takes priority.
      if (m_axis.tready) m_axis.tvalid <= 1'b0;

      if (in_fire) begin
        unique case (state)
          HDR: begin
            if (s_axis_agg.tlast) begin
              // A header-only packet carries no data; drop it.
              err_cnt <= sat_inc(err_cnt);
            end else begin
              hdr_tuser <= s_axis_agg.tuser;
              beat_idx  <= 4'd1;
              if (is_final) begin
                m_axis.tvalid <= 1'b1;
                m_axis.tdata  <= s_axis_agg.tdata;
                m_axis.tuser  <= s_axis_agg.tuser;
                m_axis.tlast  <= 1'b0;
                state         <= EMIT;
              end else begin
                state <= ABSORB;
              end
            end
          end

          ABSORB: begin
            for (int k = 0; k < NACC; k++) begin
              if (beat_idx == 4'(k + 1)) acc[k] <= beat_sum;
            end
            if (beat_idx == LAST_BEAT) begin
              beat_idx <= '0;
              if (s_axis_agg.tlast) begin
                pkt_cnt    <= pkt_cnt + 32'd1;
                worker_cnt <= worker_cnt + 8'd1;
                state      <= HDR;
              end else begin
                err_cnt <= sat_inc(err_cnt);
                state   <= DRAIN;
              end
            end else if (s_axis_agg.tlast) begin
              // Short packet: partial sums stay, the worker does not count.
              err_cnt  <= sat_inc(err_cnt);
              beat_idx <= '0;
              state    <= HDR;
            end else begin
              beat_idx <= beat_idx + 4'd1;
            end
          end

          EMIT: begin
            m_axis.tvalid <= 1'b1;
            m_axis.tdata  <= beat_sum;
            m_axis.tuser  <= hdr_tuser;
            m_axis.tlast  <= (beat_idx == LAST_BEAT) | s_axis_agg.tlast;
            for (int k = 0; k < NACC; k++) begin
              if (beat_idx == 4'(k + 1)) acc[k] <= '0;
            end
            if (beat_idx == LAST_BEAT || s_axis_agg.tlast) begin
              // Leaving EMIT by any path starts the next round from zero,
              // including slots a truncated result never reached.
              beat_idx   <= '0;
              worker_cnt <= '0;
              for (int k = 0; k < NACC; k++) acc[k] <= '0;
              if (beat_idx == LAST_BEAT && s_axis_agg.tlast) begin
                pkt_cnt <= pkt_cnt + 32'd1;
                state   <= HDR;
              end else if (beat_idx == LAST_BEAT) begin
                err_cnt <= sat_inc(err_cnt);
                state   <= DRAIN;
              end else begin
                err_cnt <= sat_inc(err_cnt);
                state   <= HDR;
              end
            end else begin
              beat_idx <= beat_idx + 4'd1;
            end
          end

          DRAIN: begin
            if (s_axis_agg.tlast) state <= HDR;
          end

          default: state <= HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_agg_reduce.sv
// ---------------------------------------------------------------------------
// tb_agg_reduce
//   Bench for agg_reduce with NUM_WORKERS=4, PKT_BEATS=3. A packet-level
//   reference model predicts every result beat; a table of hand-computed
//   rounds, a few directed corner sequences and a randomized phase drive it.
// ---------------------------------------------------------------------------
module tb_agg_reduce;

  localparam int NW = 4;
  localparam int PB = 3;
  localparam int BW = 1 + 128 + 256;   // {tlast, tuser, tdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic axis_reset = 1'b1;
  always #5 clk = ~clk;

  agg_reduce_if s_if ();
  agg_reduce_if m_if ();

  logic        round_done;
  logic [31:0] pkt_cnt;
  logic [15:0] err_cnt;
  logic [1:0]  state_dbg;
  logic [7:0]  worker_cnt_dbg;
  logic [3:0]  beat_idx_dbg;

  agg_reduce #(
    .C_AXIS_DATA_WIDTH (256),
    .C_AXIS_TUSER_WIDTH(128),
    .PKT_BEATS         (PB),
    .NUM_WORKERS       (NW)
  ) dut (
    .axis_aclk     (clk),
    .axis_reset    (axis_reset),
    .s_axis_agg    (s_if),
    .m_axis        (m_if),
    .round_done    (round_done),
    .pkt_cnt       (pkt_cnt),
    .err_cnt       (err_cnt),
    .state_dbg     (state_dbg),
    .worker_cnt_dbg(worker_cnt_dbg),
    .beat_idx_dbg  (beat_idx_dbg)
  );

  // ---------------- bench state ----------------
  int              total;
  int              bad;
  logic [BW-1:0]   exp_q[$];
  logic [BW-1:0]   got_q[$];
  int              stall_left;
  bit              rand_ready;
  int              idle_max;
  int              rd_cnt;
  longint          cyc;
  bit              prev_stall;
  logic [BW-1:0]   prev_beat;
  logic [255:0]    pkt_beat [16];

  // reference model state
  logic [31:0]     m_acc [PB][8];
  int              m_wc;
  int              m_pkt;
  int              m_err;
  int              m_rounds;

  typedef struct packed {
    logic [3:0][31:0] lane;
    logic [31:0]      exp_lane;
  } row_t;
  row_t tbl [5];

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic abort_run(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired, required DUT progress", nm);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench stopped");
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int j = 0; j < PB; j++)
      for (int l = 0; l < 8; l++) m_acc[j][l] = '0;
    m_wc  = 0;
    m_pkt = 0;
    m_err = 0;
  endtask

  // Whole-packet view: L beats, tlast on the last one.
  task automatic model_pkt(input int len, input logic [127:0] tu);
    int            nd;
    logic [255:0]  d;
    if (len == 1) begin
      m_err++;
      return;
    end
    nd = (len < PB) ? len : PB;
    if (m_wc != NW - 1) begin
      for (int j = 1; j < nd; j++)
        for (int l = 0; l < 8; l++) m_acc[j][l] = m_acc[j][l] + pkt_beat[j][l*32 +: 32];
      if (len == PB) begin
        m_pkt++;
        m_wc++;
      end else begin
        m_err++;
      end
    end else begin
      exp_q.push_back({1'b0, tu, pkt_beat[0]});
      for (int j = 1; j < nd; j++) begin
        for (int l = 0; l < 8; l++) d[l*32 +: 32] = m_acc[j][l] + pkt_beat[j][l*32 +: 32];
        exp_q.push_back({(j == nd - 1) ? 1'b1 : 1'b0, tu, d});
      end
      if (len == PB) m_pkt++;
      else m_err++;
      for (int j = 0; j < PB; j++)
        for (int l = 0; l < 8; l++) m_acc[j][l] = '0;
      m_wc = 0;
      m_rounds++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rand_user();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] r;
    for (int l = 0; l < 8; l++) r[l*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic fill_pkt(input logic [31:0] v);
    pkt_beat[0] = rand_data();
    for (int b = 1; b < 16; b++) pkt_beat[b] = {8{v}};
  endtask

  task automatic fill_rand();
    for (int b = 0; b < 16; b++) pkt_beat[b] = rand_data();
  endtask

  // ---------------- driver ----------------
  task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic last);
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (s_if.tready) begin
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        return;
      end
    end
    abort_run("send_beat");
  endtask

  task automatic send_pkt(input int len, input logic [127:0] tu);
    model_pkt(len, tu);
    for (int b = 0; b < len; b++) begin
      if (b > 0 && idle_max > 0)
        repeat ($urandom_range(0, idle_max)) begin @(posedge clk); #1; end
      send_beat(pkt_beat[b], (b == 0) ? tu : rand_user(), (b == len - 1) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic wait_idle();
    int q;
    q = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (!m_if.tvalid) q++;
      else q = 0;
      if (q >= 3) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    abort_run("wait_idle");
  endtask

  task automatic finish_reset();
    s_if.tvalid = 1'b0;
    stall_left  = 0;
    axis_reset  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    axis_reset = 1'b0;
    model_clear();
    exp_q.delete();
    got_q.delete();
    @(posedge clk);
    #1;
  endtask

  // ---------------- sink / monitor / scoreboard ----------------
  task automatic sink_loop();
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (stall_left > 0) begin
        m_if.tready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        m_if.tready = ($urandom_range(0, 3) != 0);
      end else begin
        m_if.tready = 1'b1;
      end
    end
  endtask

  task automatic monitor_loop();
    logic [BW-1:0] beat;
    forever begin
      @(negedge clk);
      beat = {m_if.tlast, m_if.tuser, m_if.tdata};
      if (axis_reset) begin
        prev_stall = 1'b0;
      end else begin
        if (round_done) rd_cnt++;
        if (prev_stall)
          check("hold_stable", 512'({m_if.tvalid, beat}), 512'({1'b1, prev_beat}));
        if (m_if.tvalid && m_if.tready) begin
          got_q.push_back(beat);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_beat: got %0h expected no beat", beat);
          end else begin
            check("out_beat", 512'(beat), 512'(exp_q.pop_front()));
          end
        end
        prev_stall = m_if.tvalid & ~m_if.tready;
        prev_beat  = beat;
      end
    end
  endtask

  // One table round: four well-formed packets with constant lanes.
  task automatic run_row(input int r);
    logic [31:0]  p0;
    int           rd0;
    longint       c0;
    logic [127:0] tu;
    logic [255:0] hd;
    p0  = pkt_cnt;
    rd0 = rd_cnt;
    got_q.delete();
    c0  = cyc;
    tu  = '0;
    hd  = '0;
    for (int k = 0; k < NW; k++) begin
      fill_pkt(tbl[r].lane[k]);
      tu = rand_user();
      hd = pkt_beat[0];
      send_pkt(PB, tu);
    end
    check("row_cycles", 512'(cyc - c0), 512'(NW * PB));
    wait_idle();
    check("row_nbeats", 512'(got_q.size()), 512'(PB));
    if (got_q.size() == PB) begin
      check("row_hdr", 512'(got_q[0]), 512'({1'b0, tu, hd}));
      check("row_d1", 512'(got_q[1]), 512'({1'b0, tu, {8{tbl[r].exp_lane}}}));
      check("row_d2", 512'(got_q[2]), 512'({1'b1, tu, {8{tbl[r].exp_lane}}}));
    end
    check("row_pkt", 512'(pkt_cnt - p0), 512'(NW));
    check("row_done", 512'(rd_cnt - rd0), 512'(1));
  endtask

  // ---------------- main ----------------
  initial begin
    logic [127:0] tu;
    logic [15:0]  e0;
    int           rd0;
    int           len;

    total = 0; bad = 0; stall_left = 0; rand_ready = 1'b0; idle_max = 0;
    rd_cnt = 0; cyc = 0; prev_stall = 1'b0; prev_beat = '0; m_rounds = 0;
    model_clear();
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    s_if.tkeep = '1;
    m_if.tready = 1'b1;

    tbl[0] = '{lane: {32'h1, 32'h1, 32'h1, 32'h1},                      exp_lane: 32'h4};
    tbl[1] = '{lane: {32'h2, 32'h2, 32'h2, 32'hFFFF_FFFF},              exp_lane: 32'h5};
    tbl[2] = '{lane: {32'h3, 32'h3, 32'h3, 32'h3},                      exp_lane: 32'hC};
    tbl[3] = '{lane: {32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000}, exp_lane: 32'h8000_0000};
    tbl[4] = '{lane: {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF},              exp_lane: 32'hDEAD_BEEF};

    fork
      sink_loop();
      monitor_loop();
    join_none

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 512'(m_if.tvalid), 512'(0));
    check("rst_tdata", 512'(m_if.tdata), 512'(0));
    check("rst_tuser", 512'(m_if.tuser), 512'(0));
    check("rst_tlast", 512'(m_if.tlast), 512'(0));
    check("rst_tkeep", 512'(m_if.tkeep), 512'(32'hFFFF_FFFF));
    check("rst_round_done", 512'(round_done), 512'(0));
    check("rst_pkt_cnt", 512'(pkt_cnt), 512'(0));
    check("rst_err_cnt", 512'(err_cnt), 512'(0));
    check("rst_state", 512'(state_dbg), 512'(0));
    check("rst_worker", 512'(worker_cnt_dbg), 512'(0));
    check("rst_beat_idx", 512'(beat_idx_dbg), 512'(0));
    check("rst_in_ready", 512'(s_if.tready), 512'(1));
    @(negedge clk);
    axis_reset = 1'b0;
    @(posedge clk);
    #1;

    // table rounds
    for (int r = 0; r < 5; r++) run_row(r);

    // output stall during the first data beat of the result
    for (int k = 0; k < NW - 1; k++) begin
      fill_pkt(32'h1);
      send_pkt(PB, rand_user());
    end
    fill_pkt(32'h1);
    tu = rand_user();
    model_pkt(PB, tu);
    send_beat(pkt_beat[0], tu, 1'b0);
    send_beat(pkt_beat[1], rand_user(), 1'b0);
    stall_left = 5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 512'(s_if.tready), 512'(0));
      check("stall_tvalid", 512'(m_if.tvalid), 512'(1));
      check("stall_tdata", 512'(m_if.tdata), 512'({8{32'h4}}));
    end
    @(posedge clk);
    #1;
    send_beat(pkt_beat[2], rand_user(), 1'b1);
    wait_idle();
    check("stall_exp_empty", 512'(exp_q.size()), 512'(0));

    // short non-final packet: error, worker count unchanged, 5 packets total
    rd0 = rd_cnt;
    fill_rand();
    send_pkt(PB, rand_user());
    e0 = err_cnt;
    fill_rand();
    send_pkt(2, rand_user());
    check("early_err", 512'(err_cnt), 512'(e0 + 16'd1));
    check("early_worker", 512'(worker_cnt_dbg), 512'(1));
    check("early_state", 512'(state_dbg), 512'(0));
    for (int k = 0; k < NW - 1; k++) begin
      fill_rand();
      send_pkt(PB, rand_user());
    end
    wait_idle();
    check("early_done", 512'(rd_cnt - rd0), 512'(1));
    check("early_exp_empty", 512'(exp_q.size()), 512'(0));

    // over-long final packet: truncated at beat 2, extra beats dropped
    for (int k = 0; k < NW - 1; k++) begin
      fill_rand();
      send_pkt(PB, rand_user());
    end
    e0 = err_cnt;
    got_q.delete();
    fill_rand();
    send_pkt(5, rand_user());
    wait_idle();
    check("long_err", 512'(err_cnt), 512'(e0 + 16'd1));
    check("long_nbeats", 512'(got_q.size()), 512'(PB));
    if (got_q.size() == PB) check("long_tlast", 512'(got_q[PB-1][BW-1]), 512'(1));
    check("long_state", 512'(state_dbg), 512'(0));
    run_row(1);
    check("counts_pkt", 512'(pkt_cnt), 512'(m_pkt));
    check("counts_err", 512'(err_cnt), 512'(m_err));

    // reset after two absorbed packets
    for (int k = 0; k < 2; k++) begin
      fill_pkt(32'h3);
      send_pkt(PB, rand_user());
    end
    axis_reset = 1'b1;
    #1;
    check("mid_rst_tvalid", 512'(m_if.tvalid), 512'(0));
    check("mid_rst_worker", 512'(worker_cnt_dbg), 512'(0));
    check("mid_rst_pkt", 512'(pkt_cnt), 512'(0));
    finish_reset();
    run_row(2);

    // reset while a result header is held in the output register
    for (int k = 0; k < NW - 1; k++) begin
      fill_pkt(32'h1);
      send_pkt(PB, rand_user());
    end
    fill_pkt(32'h1);
    stall_left = 1000;
    send_beat(pkt_beat[0], rand_user(), 1'b0);
    check("emit_pre_tvalid", 512'(m_if.tvalid), 512'(1));
    axis_reset = 1'b1;
    #1;
    check("emit_rst_tvalid", 512'(m_if.tvalid), 512'(0));
    check("emit_rst_tdata", 512'(m_if.tdata), 512'(0));
    check("emit_rst_state", 512'(state_dbg), 512'(0));
    finish_reset();
    run_row(0);

    // randomized packets and back-pressure against the model
    rand_ready = 1'b1;
    idle_max   = 2;
    for (int p = 0; p < 80; p++) begin
      fill_rand();
      case ($urandom_range(0, 9))
        0:       len = 1;
        1:       len = 2;
        2:       len = 4;
        3:       len = 5;
        default: len = PB;
      endcase
      send_pkt(len, rand_user());
    end
    wait_idle();
    rand_ready = 1'b0;
    idle_max   = 0;
    check("rand_pkt", 512'(pkt_cnt), 512'(m_pkt));
    check("rand_err", 512'(err_cnt), 512'(m_err));
    check("rand_rounds", 512'(rd_cnt), 512'(m_rounds));
    check("rand_worker", 512'(worker_cnt_dbg), 512'(m_wc));
    check("rand_exp_empty", 512'(exp_q.size()), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
